// File: rtl/coin_burst_sequencer_if.sv
// rtl/coin_burst_sequencer_if.sv - raw coin sensor lines and FSM-facing coin code outputs
interface coin_burst_sequencer_if #(
    parameter int DEPTH = 4
);
    logic                   coin5_raw;
    logic                   coin10_raw;
    logic [1:0]             coin_code;
    logic                   busy;
    logic                   reject;
    logic [$clog2(DEPTH):0] count;

    modport master (output coin5_raw, coin10_raw, input coin_code, busy, reject, count);
    modport slave  (input coin5_raw, coin10_raw, output coin_code, busy, reject, count);
endinterface

// File: rtl/coin_burst_sequencer.sv
// rtl/coin_burst_sequencer.sv - debounces coin sensors, queues coins, replays them as a contiguous burst
module coin_burst_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDLE_TIMEOUT    = 16,
    parameter int DEPTH           = 4
) (
    input logic                   clk,
    input logic                   rst,
    coin_burst_sequencer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(IDLE_TIMEOUT);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, BURST} state_t;

    // bit 0 is the 5 rs line, bit 1 the 10 rs line
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_q;
    logic [DW-1:0] deb_cnt [2];

    logic [1:0]    queue [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] occ;
    logic [TW-1:0] timer;
    state_t        state;
    logic [1:0]    code;
    logic          busy_r;
    logic          reject_r;

    logic [1:0]    ev;
    logic [1:0]    ev_code;
    logic          accept;
    logic          refuse;
    logic          pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= {bus.coin10_raw, bus.coin5_raw};
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_comb begin
        ev      = deb & ~deb_q;
        ev_code = ev[1] ? 2'b10 : 2'b01;
        accept  = (ev != 2'b00) && (ev != 2'b11) && (state != BURST) && (occ != FULL);
        refuse  = (ev != 2'b00) && !accept;
        pop     = (state == BURST) && (occ != '0);
    end

    // Queue storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) queue[tail] <= ev_code;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            timer    <= '0;
            code     <= 2'b00;
            busy_r   <= 1'b0;
            reject_r <= 1'b0;
        end else begin
            reject_r <= refuse;
            occ      <= occ + CW'(accept) - CW'(pop);
            if (accept) tail <= tail + PW'(1);
            case (state)
                IDLE: begin
                    code <= 2'b00;
                    if (accept) begin
                        state  <= COLLECT;
                        busy_r <= 1'b1;
                        timer  <= '0;
                    end
                end
                COLLECT: begin
                    if (occ == FULL) begin
                        state <= BURST;
                    end else if (accept) begin
                        timer <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state <= BURST;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                BURST: begin
                    // Leave only once the queue has drained so 00 and busy low coincide.
                    if (occ == '0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        code   <= 2'b00;
                    end else begin
                        code <= queue[head];
                        head <= head + PW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    code   <= 2'b00;
                end
            endcase
        end
    end

    assign bus.coin_code = code;
    assign bus.busy      = busy_r;
    assign bus.reject    = reject_r;
    assign bus.count     = occ;
endmodule
